// File: rtl/counter_mode_detector_pkg.sv
// Shared step-class codes, FSM state encoding and a saturating run-counter helper
// for the counter mode detector.
package counter_mode_pkg;

    localparam logic [1:0] CLS_INC1 = 2'b00;
    localparam logic [1:0] CLS_INC2 = 2'b01;
    localparam logic [1:0] CLS_DEC1 = 2'b10;
    localparam logic [1:0] CLS_RST  = 2'b11;

    localparam int unsigned RUN_W = 4;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] r);
        return (r == '1) ? r : r + RUN_W'(1);
    endfunction

endpackage

// File: rtl/counter_mode_detector_step_classifier.sv
// Combinational step classifier: maps (prev, q_in) to a step class using
// modular delta first, then the jump-to-zero reset case.
module step_classifier
    import counter_mode_pkg::*;
#(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0] prev,
    input  logic [W-1:0] q_in,
    output logic [1:0]   cls,
    output logic         invalid
);

    logic [W-1:0] delta;

    assign delta = q_in - prev;

    // Arithmetic classes win over reset, so wrap steps like 7->0 stay +1.
    always_comb begin
        cls     = CLS_INC1;
        invalid = 1'b0;
        if (delta == W'(1)) begin
            cls = CLS_INC1;
        end else if (delta == W'(2)) begin
            cls = CLS_INC2;
        end else if (delta == '1) begin
            cls = CLS_DEC1;
        end else if (q_in == '0) begin
            cls = CLS_RST;
        end else begin
            invalid = 1'b1;
        end
    end

endmodule

// File: rtl/counter_mode_detector.sv
// Counter mode detector: classifies each observed step of the sel-driven counter
// and locks onto a repeated mode. Optional break counter via MODE_DET_ERRCNT_EN.
module counter_mode_detector
    import counter_mode_pkg::*;
#(
    parameter int unsigned W        = 3,
    parameter int unsigned LOCK_CNT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] q_in,
    input  logic         q_valid,
    output logic [1:0]   step_class,
    output logic         class_valid,
    output logic         invalid,
    output logic         lock,
    output logic [1:0]   mode,
    output logic         err
`ifdef MODE_DET_ERRCNT_EN
    ,
    output logic [7:0]   err_cnt
`endif
);

    localparam logic [RUN_W-1:0] LOCK_THR = RUN_W'(LOCK_CNT);

    state_t           state;
    logic [W-1:0]     prev;
    logic [RUN_W-1:0] run;
    logic [1:0]       last_cls;

    logic [1:0]       cls;
    logic             cls_inv;
    logic [RUN_W-1:0] run_next;
    logic             lock_hit;
    logic             brk;

    step_classifier #(
        .W(W)
    ) u_classifier (
        .prev   (prev),
        .q_in   (q_in),
        .cls    (cls),
        .invalid(cls_inv)
    );

    // last_cls follows mode while locked, so a break naturally restarts the run at 1.
    always_comb begin
        run_next = '0;
        if (!cls_inv) begin
            if (run != '0 && cls == last_cls) begin
                run_next = run_sat_inc(run);
            end else begin
                run_next = RUN_W'(1);
            end
        end
    end

    assign lock_hit = !cls_inv && (run_next >= LOCK_THR);
    assign brk      = q_valid && (state == LOCKED) && (cls_inv || cls != mode);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            prev        <= '0;
            run         <= '0;
            last_cls    <= CLS_INC1;
            step_class  <= CLS_INC1;
            class_valid <= 1'b0;
            invalid     <= 1'b0;
            lock        <= 1'b0;
            mode        <= CLS_INC1;
            err         <= 1'b0;
        end else begin
            class_valid <= 1'b0;
            invalid     <= 1'b0;
            err         <= 1'b0;
            if (q_valid) begin
                prev <= q_in;
                case (state)
                    EMPTY: begin
                        run   <= '0;
                        state <= ACQ;
                    end
                    ACQ: begin
                        class_valid <= 1'b1;
                        step_class  <= cls;
                        invalid     <= cls_inv;
                        last_cls    <= cls;
                        run         <= run_next;
                        if (lock_hit) begin
                            lock  <= 1'b1;
                            mode  <= cls;
                            state <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        class_valid <= 1'b1;
                        step_class  <= cls;
                        invalid     <= cls_inv;
                        last_cls    <= cls;
                        run         <= run_next;
                        if (brk) begin
                            err <= 1'b1;
                            // Only reachable with LOCK_CNT=1: break and re-lock together.
                            if (lock_hit) begin
                                mode <= cls;
                            end else begin
                                lock  <= 1'b0;
                                state <= ACQ;
                            end
                        end
                    end
                    default: begin
                        state <= EMPTY;
                    end
                endcase
            end
        end
    end

`ifdef MODE_DET_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (brk && err_cnt != '1) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_counter_mode_detector.sv
// Scoreboard bench for counter_mode_detector (W=3, LOCK_CNT=3); err_cnt checks
// are compiled only with MODE_DET_ERRCNT_EN.
module tb_counter_mode_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] q_in = '0;
    logic       q_valid = 1'b0;
    logic [1:0] step_class;
    logic       class_valid;
    logic       invalid;
    logic       lock;
    logic [1:0] mode;
    logic       err;
`ifdef MODE_DET_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    typedef struct {
        logic [1:0] cls;
        logic       inv;
        logic       lk;
        logic [1:0] md;
        logic       er;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    counter_mode_detector #(
        .W(3),
        .LOCK_CNT(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .q_in       (q_in),
        .q_valid    (q_valid),
        .step_class (step_class),
        .class_valid(class_valid),
        .invalid    (invalid),
        .lock       (lock),
        .mode       (mode),
        .err        (err)
`ifdef MODE_DET_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one sample; when exp_out is set, queue the response the DUT must show next cycle.
    task automatic send(input logic [2:0] q, input bit exp_out, input logic [1:0] c,
                        input logic iv, input logic lk, input logic [1:0] md, input logic er);
        exp_t e;
        @(posedge clk);
        #1;
        q_in    = q;
        q_valid = 1'b1;
        if (exp_out) begin
            e.cls = c; e.inv = iv; e.lk = lk; e.md = md; e.er = er;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        q_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && err && !class_valid) begin
            chk("err_without_class_valid", 8'd1, 8'd0);
        end
        if (!rst && class_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_class_valid", 8'd1, 8'd0);
            end else begin
                e = sb.pop_front();
                chk("invalid", {7'd0, invalid}, {7'd0, e.inv});
                if (!e.inv) chk("step_class", {6'd0, step_class}, {6'd0, e.cls});
                chk("lock", {7'd0, lock}, {7'd0, e.lk});
                if (e.lk) chk("mode", {6'd0, mode}, {6'd0, e.md});
                chk("err", {7'd0, err}, {7'd0, e.er});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] q;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_class_valid", {7'd0, class_valid}, 8'd0);
        chk("rst_lock", {7'd0, lock}, 8'd0);
        chk("rst_err", {7'd0, err}, 8'd0);
        chk("rst_step_class", {6'd0, step_class}, 8'd0);
        chk("rst_mode", {6'd0, mode}, 8'd0);
`ifdef MODE_DET_ERRCNT_EN
        chk("rst_err_cnt", err_cnt, 8'd0);
`endif
        rst = 1'b0;

        // +1 run: lock on the third step
        send(3'd0, 0, 2'b00, 0, 0, 2'b00, 0);
        send(3'd1, 1, 2'b00, 0, 0, 2'b00, 0);
        send(3'd2, 1, 2'b00, 0, 0, 2'b00, 0);
        send(3'd3, 1, 2'b00, 0, 1, 2'b00, 0);
        send(3'd4, 1, 2'b00, 0, 1, 2'b00, 0);
        send(3'd5, 1, 2'b00, 0, 1, 2'b00, 0);
        // break to +2, wrap 7->1 is +2
        send(3'd7, 1, 2'b01, 0, 0, 2'b00, 1);
        send(3'd1, 1, 2'b01, 0, 0, 2'b00, 0);
        send(3'd3, 1, 2'b01, 0, 1, 2'b01, 0);
        send(3'd5, 1, 2'b01, 0, 1, 2'b01, 0);
        // invalid break, then -1 including 1->0 and 0->7
        send(3'd2, 1, 2'b00, 1, 0, 2'b00, 1);
        send(3'd1, 1, 2'b10, 0, 0, 2'b00, 0);
        send(3'd0, 1, 2'b10, 0, 0, 2'b00, 0);
        send(3'd7, 1, 2'b10, 0, 1, 2'b10, 0);
        send(3'd6, 1, 2'b10, 0, 1, 2'b10, 0);
        // invalid break, then reset class (4->0, 0->0, 0->0)
        send(3'd4, 1, 2'b00, 1, 0, 2'b00, 1);
        send(3'd0, 1, 2'b11, 0, 0, 2'b00, 0);
        send(3'd0, 1, 2'b11, 0, 0, 2'b00, 0);
        send(3'd0, 1, 2'b11, 0, 1, 2'b11, 0);
        idle(); idle();
        send(3'd3, 1, 2'b00, 1, 0, 2'b00, 1);
        idle(); idle(); idle();
        send(3'd5, 1, 2'b01, 0, 0, 2'b00, 0);
        idle();
        // invalid steps in ACQ clear the run
        send(3'd1, 1, 2'b00, 1, 0, 2'b00, 0);
        send(3'd4, 1, 2'b00, 1, 0, 2'b00, 0);
        send(3'd5, 1, 2'b00, 0, 0, 2'b00, 0);
        send(3'd6, 1, 2'b00, 0, 0, 2'b00, 0);
        send(3'd7, 1, 2'b00, 0, 1, 2'b00, 0);
        send(3'd0, 1, 2'b00, 0, 1, 2'b00, 0);
        idle();
        @(negedge clk);
`ifdef MODE_DET_ERRCNT_EN
        chk("err_cnt_after_4_breaks", err_cnt, 8'd4);
        q = 3'd0;
        for (int i = 0; i < 300; i++) begin
            q = q + 3'd2;
            send(q, 1, 2'b01, 0, 0, 2'b00, 1);
            q = q + 3'd1;
            send(q, 1, 2'b00, 0, 0, 2'b00, 0);
            q = q + 3'd1;
            send(q, 1, 2'b00, 0, 0, 2'b00, 0);
            q = q + 3'd1;
            send(q, 1, 2'b00, 0, 1, 2'b00, 0);
        end
        idle();
        @(negedge clk);
        chk("err_cnt_saturated", err_cnt, 8'd255);
`else
        q = 3'd0;
`endif
        chk("locked_before_rst", {7'd0, lock}, 8'd1);

        // reset while locked with a valid sample present
        @(posedge clk);
        #1;
        rst = 1'b1;
        q_in = q + 3'd1;
        q_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_class_valid", {7'd0, class_valid}, 8'd0);
        chk("midrst_lock", {7'd0, lock}, 8'd0);
        chk("midrst_invalid", {7'd0, invalid}, 8'd0);
        chk("midrst_err", {7'd0, err}, 8'd0);
        chk("midrst_mode", {6'd0, mode}, 8'd0);
        chk("midrst_step_class", {6'd0, step_class}, 8'd0);
`ifdef MODE_DET_ERRCNT_EN
        chk("midrst_err_cnt", err_cnt, 8'd0);
`endif
        rst = 1'b0;
        q_valid = 1'b0;

        // EMPTY after reset: first sample yields no class
        send(3'd0, 0, 2'b00, 0, 0, 2'b00, 0);
        send(3'd1, 1, 2'b00, 0, 0, 2'b00, 0);
        idle();

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            chk("scoreboard_drained", 8'(sb.size()), 8'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
